// File: rtl/lifo_driver_pkg.sv
// Shared op encodings, FSM states and default sizing for the LIFO command driver.
// Pure declarations: no logic, no latency, no flow control.
package lifo_drv_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_RD_LAT = 1;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_PEEK = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POP,
    ST_CAPT,
    ST_PUSHB,
    ST_SETTLE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/lifo_driver_if.sv
// Host command/response handshake plus the LIFO access port, bundled for the driver.
// master = driver side, slave = host/LIFO environment side.
interface lifo_driver_if
  import lifo_drv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [WIDTH-1:0] cmd_data;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  logic [WIDTH-1:0] dataIn;
  logic             RW;
  logic             EN;
  logic [WIDTH-1:0] dataOut;
  logic             EMPTY;
  logic             FULL;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, dataOut, EMPTY, FULL,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, dataIn, RW, EN
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, dataOut, EMPTY, FULL,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, dataIn, RW, EN
  );

endinterface

// File: rtl/lifo_driver.sv
// Turns host PUSH/POP/PEEK commands into single-cycle LIFO strobes; latency 3 / 3+RD_LAT / 4+RD_LAT, errors 1.
// One command in flight: cmd_ready only in IDLE, response held in RESP until rsp_ready.
module lifo_driver
  import lifo_drv_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic Clk,
  input  logic Rst,
  lifo_driver_if.master bus
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             rw_q, rw_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             accept;
  logic             bad_cmd;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_PUSH;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      rw_q       <= 1'b1;
      din_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      rw_q       <= rw_d;
      din_q      <= din_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE) && !Rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  // Flags are checked against the op in the accept cycle itself.
  assign bad_cmd = (bus.cmd_op == OP_ILL) ||
                   ((bus.cmd_op == OP_PUSH) && bus.FULL) ||
                   (((bus.cmd_op == OP_POP) || (bus.cmd_op == OP_PEEK)) && bus.EMPTY);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    en_d       = 1'b0;
    rw_d       = rw_q;
    din_d      = din_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d       = bus.cmd_op;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if (bad_cmd) begin
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end else if (bus.cmd_op == OP_PUSH) begin
            en_d    = 1'b1;
            rw_d    = 1'b0;
            din_d   = bus.cmd_data;
            state_d = ST_PUSH;
          end else begin
            en_d    = 1'b1;
            rw_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_POP;
          end
        end
      end
      ST_PUSH: state_d = ST_SETTLE;
      // Strobe lasts only the first POP cycle; the rest is the read-latency wait.
      ST_POP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPT: begin
        rsp_data_d = bus.dataOut;
        if (op_q == OP_PEEK) begin
          en_d    = 1'b1;
          rw_d    = 1'b0;
          din_d   = bus.dataOut;
          state_d = ST_PUSHB;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_PUSHB:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.EN        = en_q;
  assign bus.RW        = rw_q;
  assign bus.dataIn    = din_q;

endmodule

// File: tb/tb_lifo_driver.sv
// Directed bench for lifo_driver with a behavioural LIFO (RD_LAT=1) and a response scoreboard.
module tb_lifo_driver;
  import lifo_drv_pkg::*;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
    int          en;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  lifo_driver_if #(.WIDTH(16)) bus ();

  lifo_driver #(.WIDTH(16), .RD_LAT(1)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.master)
  );

  // Behavioural LIFO: registered read data and flags.
  localparam int DEPTH = 8;
  logic [15:0] stk[$];
  logic [15:0] dout_q   = 16'h0;
  logic        empty_q  = 1'b1;
  logic        full_q   = 1'b0;
  logic        empty_frc = 1'b0;
  logic        full_frc  = 1'b0;

  assign bus.dataOut = dout_q;
  assign bus.EMPTY   = empty_q | empty_frc;
  assign bus.FULL    = full_q | full_frc;

  always @(posedge Clk) begin
    if (bus.EN) begin
      if (!bus.RW) stk.push_back(bus.dataIn);
      else if (stk.size() > 0) dout_q <= stk.pop_back();
    end
    empty_q <= (stk.size() == 0);
    full_q  <= (stk.size() >= DEPTH);
  end

  int          en_cnt = 0;
  int          consec_err = 0;
  logic        en_prev = 1'b0;
  logic [15:0] push_last = 16'h0;

  always @(posedge Clk) begin
    en_prev <= bus.EN;
    if (bus.EN) begin
      en_cnt <= en_cnt + 1;
      if (!bus.RW) push_last <= bus.dataIn;
      if (en_prev) consec_err <= consec_err + 1;
    end
  end

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input op_e op, input logic [15:0] d, input exp_t e, input int hold);
    int n;
    int en_base;
    int lat;
    exp_t got;
    logic [15:0] held;
    @(negedge Clk);
    bus.rsp_ready = (hold == 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("accept_ready", {31'b0, bus.cmd_ready}, 32'd1);
    en_base = en_cnt;
    sb.push_back(e);
    @(posedge Clk);
    #1 bus.cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (!bus.rsp_valid && lat < 30);
    got = sb.pop_front();
    chk("rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("latency", lat, got.lat);
    chk("rsp_data", {16'b0, bus.rsp_data}, {16'b0, got.data});
    chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, got.err});
    chk("en_pulses", en_cnt - en_base, got.en);
    if (hold > 0) begin
      held = bus.rsp_data;
      for (int i = 0; i < hold; i++) begin
        @(negedge Clk);
        chk("stall_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("stall_data", {16'b0, bus.rsp_data}, {16'b0, held});
        chk("stall_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
      end
      bus.rsp_ready = 1'b1;
    end
  endtask

  initial begin
    int depth0;
    int en_base;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_PUSH;
    bus.cmd_data  = 16'h0;
    bus.rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge Clk);
    chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    chk("rst_en", {31'b0, bus.EN}, 32'd0);
    chk("rst_rw", {31'b0, bus.RW}, 32'd1);
    chk("rst_din", {16'b0, bus.dataIn}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'b0, bus.rsp_data}, 32'd0);
    chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("post_rst_ready", {31'b0, bus.cmd_ready}, 32'd1);

    // Legal PUSH
    do_cmd(OP_PUSH, 16'h000A, '{data: 16'h0, err: 1'b0, lat: 3, en: 1}, 0);
    chk("push_din", {16'b0, bus.dataIn}, 32'h000A);
    chk("push_rw", {31'b0, bus.RW}, 32'd0);
    chk("push_depth", stk.size(), 32'd1);

    // POP returning 0x0004
    do_cmd(OP_PUSH, 16'h0004, '{data: 16'h0, err: 1'b0, lat: 3, en: 1}, 0);
    do_cmd(OP_POP, 16'h0, '{data: 16'h0004, err: 1'b0, lat: 4, en: 1}, 0);
    chk("pop_rw", {31'b0, bus.RW}, 32'd1);
    chk("pop_depth", stk.size(), 32'd1);
    chk("pop_din_held", {16'b0, bus.dataIn}, 32'h0004);

    // PEEK of 0x0006 restores the stack
    do_cmd(OP_PUSH, 16'h0006, '{data: 16'h0, err: 1'b0, lat: 3, en: 1}, 0);
    depth0 = stk.size();
    do_cmd(OP_PEEK, 16'h0, '{data: 16'h0006, err: 1'b0, lat: 5, en: 2}, 0);
    chk("peek_pushback", {16'b0, push_last}, 32'h0006);
    chk("peek_depth", stk.size(), depth0);
    chk("peek_top", {16'b0, stk[stk.size()-1]}, 32'h0006);

    // Error cases: no strobe, single-cycle response
    full_frc = 1'b1;
    do_cmd(OP_PUSH, 16'h0055, '{data: 16'h0, err: 1'b1, lat: 1, en: 0}, 0);
    full_frc = 1'b0;
    empty_frc = 1'b1;
    do_cmd(OP_POP, 16'h0, '{data: 16'h0, err: 1'b1, lat: 1, en: 0}, 0);
    do_cmd(OP_PEEK, 16'h0, '{data: 16'h0, err: 1'b1, lat: 1, en: 0}, 0);
    empty_frc = 1'b0;
    do_cmd(OP_ILL, 16'h0, '{data: 16'h0, err: 1'b1, lat: 1, en: 0}, 0);
    chk("err_din_held", {16'b0, bus.dataIn}, 32'h0006);
    chk("err_depth", stk.size(), depth0);

    // Response stall with nonzero data
    do_cmd(OP_PUSH, 16'h0033, '{data: 16'h0, err: 1'b0, lat: 3, en: 1}, 0);
    do_cmd(OP_PEEK, 16'h0, '{data: 16'h0033, err: 1'b0, lat: 5, en: 2}, 5);
    @(negedge Clk);
    chk("stall_release", {31'b0, bus.rsp_valid}, 32'd0);

    // Reset during the CAPT cycle of a PEEK
    depth0 = stk.size();
    @(negedge Clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_PEEK;
    chk("abort_ready", {31'b0, bus.cmd_ready}, 32'd1);
    en_base = en_cnt;
    @(posedge Clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk("abort_en", {31'b0, bus.EN}, 32'd0);
    chk("abort_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("abort_idle", {31'b0, bus.cmd_ready}, 32'd1);
    repeat (4) @(negedge Clk);
    chk("abort_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    chk("abort_pulses", en_cnt - en_base, 32'd1);
    chk("abort_depth", stk.size(), depth0 - 1);
    chk("abort_din", {16'b0, bus.dataIn}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    chk("en_single_cycle", consec_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lifo_driver.md
LIFO_DRIVER -- requirements
Module: lifo_driver

Interface
REQ-001 Parameter WIDTH, default 16: data width of host and LIFO data ports.
REQ-002 Parameter RD_LAT, default 1: cycles from the LIFO pop-issue edge to valid dataOut.
REQ-003 Clk  input  1  single clock; all logic rising-edge.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 cmd_valid  input  1  host command present.
REQ-006 cmd_ready  output  1  driver accepts a command this cycle.
REQ-007 cmd_op  input  2  00 PUSH, 01 POP, 10 PEEK, 11 illegal.
REQ-008 cmd_data  input  WIDTH  value to push.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  host accepts the response.
REQ-011 rsp_data  output  WIDTH  popped or peeked value; 0 for PUSH or error.
REQ-012 rsp_err  output  1  overflow, underflow or illegal op.
REQ-013 dataIn  output  WIDTH  push data to the LIFO.
REQ-014 RW  output  1  0 = push (write), 1 = pop (read).
REQ-015 EN  output  1  one-cycle LIFO access strobe.
REQ-016 dataOut  input  WIDTH  LIFO read data.
REQ-017 EMPTY, FULL  input  1 each  registered LIFO status; valid one cycle after an access.

Function
REQ-018 The FSM SHALL use states IDLE, PUSH, POP, CAPT, PUSHB, SETTLE, RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1, and cmd_op/cmd_data are registered.
REQ-020 On accept, the FSM SHALL check the flags in the same cycle: PUSH with FULL=1, POP or PEEK with EMPTY=1, or op 11 -> RESP with rsp_err=1, rsp_data=0, and no EN pulse.
REQ-021 Legal PUSH: PUSH state drives EN=1, RW=0, dataIn=captured data for exactly one cycle -> SETTLE.
REQ-022 Legal POP/PEEK: POP state drives EN=1, RW=1 for one cycle, then waits RD_LAT cycles -> CAPT, which latches dataOut into rsp_data.
REQ-023 POP: CAPT -> SETTLE. PEEK: CAPT -> PUSHB, which drives EN=1, RW=0, dataIn=captured value for one cycle -> SETTLE, restoring the stack.
REQ-024 SETTLE SHALL last exactly one cycle (flag update) -> RESP.
REQ-025 RESP holds rsp_valid=1 and stable rsp_data/rsp_err until rsp_ready=1, then -> IDLE; back-to-back commands SHALL have a minimum gap of one IDLE cycle.
REQ-026 EN SHALL be 1 only in PUSH, POP and PUSHB, and never for more than one consecutive cycle per access.
REQ-027 Outside access cycles, RW SHALL hold its last value and dataIn SHALL hold the last pushed value.
REQ-028 Latency SHALL be: legal PUSH accept to rsp_valid = 3 cycles; POP = 3+RD_LAT cycles; PEEK = 4+RD_LAT cycles; error = 1 cycle.

Reset
REQ-029 On Rst=1 at a Clk edge: state=IDLE, EN=0, RW=1, dataIn=0, rsp_valid=0, rsp_data=0, rsp_err=0, cmd_ready=0 during reset, and 1 on the first cycle after release.
REQ-030 Rst mid-operation SHALL abandon the command with no response; a PEEK aborted after POP leaves the stack one entry short, which is the host's responsibility.
REQ-031 Rst SHALL take priority over every other input.

Structure
REQ-032 A shared package lifo_drv_pkg SHALL hold the op encodings, the state enumeration and the WIDTH/RD_LAT defaults.
REQ-033 The block is a single flat FSM with a datapath register; no sub-module, and the RD_LAT wait counter is inline.

Verification
REQ-034 Reset then PUSH 0x000A with FULL=0 -> one EN pulse, RW=0, dataIn=0x000A; rsp_valid 3 cycles after accept, rsp_err=0.
REQ-035 POP with dataOut model returning 0x0004 -> EN with RW=1, rsp_data=0x0004, rsp_err=0.
REQ-036 PEEK with top 0x0006 -> a pop pulse then a push pulse of 0x0006; rsp_data=0x0006; model depth unchanged.
REQ-037 PUSH with FULL=1, POP with EMPTY=1, and op 11 -> no EN, rsp_err=1, rsp_data=0, 1-cycle latency.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout.
REQ-039 Rst asserted in the CAPT cycle of a PEEK -> next cycle IDLE, EN=0, rsp_valid=0, and no push-back issued.
